// File: rtl/alu_pkg.sv
// ============================================================================
//  alu_pkg : opcode and FSM state encodings shared by alu_mdu and its bench
//  Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_MULTU = 4'b0100;
    localparam logic [3:0] OP_DIVU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/alu_mdu_iter.sv
// ============================================================================
//  alu_mdu_iter : one-bit-per-cycle unsigned shift-add multiplier / restoring divider
//  Rev 1.0
// ============================================================================
`default_nettype none

module alu_mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH:0]   w_sum, w_shift, w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;

    // Both ops share hi/lo: multiply shifts the product right through lo,
    // divide shifts the dividend left out of lo while quotient bits enter.
    always_comb begin
        w_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        w_shift = {hi_q, lo_q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, opnd_q};
        w_ge    = (w_shift >= {1'b0, opnd_q});
        if (is_div_q) begin
            w_hi_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_lo_nxt = {lo_q[WIDTH-2:0], w_ge};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        if (start_i) begin
            cnt_d    = CW'(WIDTH);
            hi_d     = '0;
            lo_d     = a_i;
            opnd_d   = b_i;
            is_div_d = is_div_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            hi_d  = w_hi_nxt;
            lo_d  = w_lo_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
        end
    end

    // Final-iteration values are exposed combinationally so the top can
    // capture them on the same edge that leaves MUL/DIV.
    assign done_o = (cnt_q == CW'(1));
    assign lo_o   = w_lo_nxt;
    assign hi_o   = w_hi_nxt;

endmodule

`default_nettype wire

// File: rtl/alu_mdu.sv
// ============================================================================
//  alu_mdu : registered EX-stage ALU with optional iterative MULTU/DIVU unit
//  Rev 1.0
// ============================================================================
`default_nettype none

module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MDU_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             zero_q, zero_d, overflow_q, overflow_d;

    logic             w_accept, w_is_mul, w_is_div;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_lo, w_iter_hi;
    logic [WIDTH-1:0] w_add, w_sub, w_alu_res;
    logic             w_alu_ov;
    logic [SHW-1:0]   w_shamt;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_is_mul  = MDU_EN && (alu_control == OP_MULTU);
    assign w_is_div  = MDU_EN && (alu_control == OP_DIVU);
    assign w_add     = a + b;
    assign w_sub     = a - b;
    assign w_shamt   = b[SHW-1:0];

    always_comb begin
        w_alu_res = '0;
        w_alu_ov  = 1'b0;
        case (alu_control)
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_XOR:  w_alu_res = a ^ b;
            OP_NOR:  w_alu_res = ~(a | b);
            OP_ADD: begin
                w_alu_res = w_add;
                w_alu_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_sub;
                w_alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  w_alu_res = a << w_shamt;
            OP_SRL:  w_alu_res = a >> w_shamt;
            OP_SRA:  w_alu_res = WIDTH'($signed(a) >>> w_shamt);
            default: w_alu_res = '0;
        endcase
    end

    generate
        if (MDU_EN) begin : g_mdu
            alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
                .clk      (clk),
                .rst_n    (rst_n),
                .start_i  (w_accept && (w_is_mul || w_is_div)),
                .is_div_i (w_is_div),
                .a_i      (a),
                .b_i      (b),
                .done_o   (w_iter_done),
                .lo_o     (w_iter_lo),
                .hi_o     (w_iter_hi)
            );
        end else begin : g_no_mdu
            assign w_iter_done = 1'b0;
            assign w_iter_lo   = '0;
            assign w_iter_hi   = '0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        state_d = ST_MUL;
                    end else if (w_is_div) begin
                        state_d = ST_DIV;
                    end else begin
                        state_d     = ST_DONE;
                        result_d    = w_alu_res;
                        result_hi_d = '0;
                        zero_d      = (w_alu_res == '0);
                        overflow_d  = w_alu_ov;
                    end
                end else if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_iter_done) begin
                    state_d     = ST_DONE;
                    result_d    = w_iter_lo;
                    result_hi_d = w_iter_hi;
                    zero_d      = (w_iter_lo == '0);
                    overflow_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// ============================================================================
//  tb_alu_mdu : scoreboard bench for alu_mdu (WIDTH=32, MDU_EN=1)
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_mdu;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    alu_control;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          zero;
    logic          overflow;
    logic          busy;

    alu_mdu #(.WIDTH(W), .MDU_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .zero        (zero),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        ov;
        int          lat;
        int          acc;
        logic [3:0]  op;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   cyc        = 0;
    int   ordy_mode  = 1;   // 0 = hold off, 1 = always ready, 2 = random
    bit   fresh      = 1'b1;
    int   busy_seen  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ordy_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
        else                out_ready = (ordy_mode == 1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy, s;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.res = '0; e.hi = '0; e.ov = 1'b0; e.lat = 1; e.acc = 0; e.op = op;
        case (op)
            OP_AND:  e.res = x & y;
            OP_OR:   e.res = x | y;
            OP_XOR:  e.res = x ^ y;
            OP_NOR:  e.res = ~(x | y);
            OP_ADD: begin
                s = sx + sy; e.res = x + y;
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                s = sx - sy; e.res = x - y;
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SLT:  e.res = (sx < sy) ? 32'd1 : 32'd0;
            OP_SLTU: e.res = (x < y) ? 32'd1 : 32'd0;
            OP_SLL:  e.res = x << y[4:0];
            OP_SRL:  e.res = x >> y[4:0];
            OP_SRA:  e.res = 32'(sx >>> y[4:0]);
            OP_MULTU: begin
                p = {32'd0, x} * {32'd0, y};
                e.res = p[31:0]; e.hi = p[63:32]; e.lat = W + 1;
            end
            OP_DIVU: begin
                if (y == 32'd0) begin e.res = 32'hFFFF_FFFF; e.hi = x; end
                else            begin e.res = x / y;         e.hi = x % y; end
                e.lat = W + 1;
            end
            default: e.res = '0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance
    // with in_valid still high so the next op can follow back-to-back.
    task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        bit   ok = 1'b0;
        in_valid = 1'b1; alu_control = op; a = x; b = y;
        for (int t = 0; t < 300 && !ok; t++) begin
            #1;
            if (in_ready) begin
                e = model(op, x, y);
                e.acc = cyc;
                exp_q.push_back(e);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; alu_control = 4'($urandom);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: latency/busy on first sight of a result, stability while
    // held, and full compare against the scoreboard on retire.
    initial begin : monitor
        logic [31:0] pr, ph;
        logic        pz, pov;
        bit          hold;
        exp_t        e;
        hold = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                check("hold_result", {32'd0, result}, {32'd0, pr});
                check("hold_hi", {32'd0, result_hi}, {32'd0, ph});
                check("hold_flags", {62'd0, zero, overflow}, {62'd0, pz, pov});
            end
            if (busy && fresh) busy_seen++;
            if (out_valid && fresh) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    e = exp_q[0];
                    check($sformatf("latency_op%0h", e.op), 64'(cyc - e.acc), 64'(e.lat));
                    check($sformatf("busy_cycles_op%0h", e.op), 64'(busy_seen), 64'(e.lat - 1));
                end
                fresh = 1'b0;
            end
            hold = out_valid && !out_ready;
            pr = result; ph = result_hi; pz = zero; pov = overflow;
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("result_op%0h", e.op), {32'd0, result}, {32'd0, e.res});
                check($sformatf("result_hi_op%0h", e.op), {32'd0, result_hi}, {32'd0, e.hi});
                check($sformatf("zero_op%0h", e.op), {63'd0, zero}, {63'd0, e.z});
                check($sformatf("overflow_op%0h", e.op), {63'd0, overflow}, {63'd0, e.ov});
                fresh = 1'b1;
                busy_seen = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_result"}, {32'd0, result}, 64'd0);
        check({tag, "_result_hi"}, {32'd0, result_hi}, 64'd0);
        check({tag, "_flags"}, {62'd0, zero, overflow}, 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] edges [5];
        logic [31:0] x, y;
        bit          drained;
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alu_control = '0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases, consumer always ready.
        do_op(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        do_op(OP_SUB, 32'd5, 32'd5);
        do_op(OP_SLT, 32'hFFFF_FFFF, 32'd1);
        do_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        do_op(OP_SRA, 32'h8000_00F0, 32'd4);
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(OP_DIVU, 32'd100, 32'd7);
        do_op(OP_DIVU, 32'd9, 32'd0);
        do_op(4'b1111, 32'h1234, 32'h5678);
        idle(2);

        // Backpressure: result held while the consumer stalls.
        ordy_mode = 0;
        @(negedge clk);
        do_op(OP_ADD, 32'h0000_1234, 32'h0000_1111);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; alu_control = OP_SUB; a = $urandom; b = $urandom;
            #1;
            check("in_ready_stalled", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        ordy_mode = 1;
        idle(3);

        // Asynchronous reset in the middle of a multiply.
        do_op(OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
        idle(9);
        #3 rst_n = 1'b0;
        exp_q.delete();
        fresh = 1'b1;
        busy_seen = 0;
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(OP_ADD, 32'd2, 32'd3);
        idle(2);

        // Randomised traffic with random consumer backpressure.
        ordy_mode = 2;
        for (int n = 0; n < 200; n++) begin
            x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            do_op(4'($urandom_range(0, 15)), x, y);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        ordy_mode = 1;

        drained = 1'b0;
        for (int t = 0; t < 3000 && !drained; t++) begin
            @(negedge clk);
            drained = (exp_q.size() == 0);
        end
        if (!drained) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
